sv32_translate_access: RTL and testbench

Parametrised Sv32 address-translation unit serving instruction fetch, load and store requests through one request/ready port. It sits between a core access port and the shared page-table walker. A small fully-associative TLB answers hits without a walk. Permission checks are access-type-aware: they cover SUM/MXR, A/D and megapage-alignment faults. Machine mode, or `satp_sv32_mode` clear, bypasses translation.

---
 rtl/sv32_pkg.sv | 68 ++++++
 rtl/sv32_translate_access_if.sv | 25 ++
 rtl/sv32_tlb.sv | 85 ++++++++
 rtl/sv32_translate_access.sv | 123 ++++++++++++
 tb/tb_sv32_translate_access.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/sv32_pkg.sv
// Shared Sv32 definitions: access/privilege encodings, PTE field positions,
// translation FSM states and the permission check used by hit and walk paths.
package sv32_pkg;

    localparam logic [1:0] ACC_FETCH = 2'd0;
    localparam logic [1:0] ACC_LOAD  = 2'd1;
    localparam logic [1:0] ACC_STORE = 2'd2;
    localparam logic [1:0] ACC_RSVD  = 2'd3;

    localparam logic [1:0] PRIV_U = 2'd0;
    localparam logic [1:0] PRIV_S = 2'd1;
    localparam logic [1:0] PRIV_M = 2'd3;

    localparam int PTE_V = 0;
    localparam int PTE_R = 1;
    localparam int PTE_W = 2;
    localparam int PTE_X = 3;
    localparam int PTE_U = 4;
    localparam int PTE_G = 5;
    localparam int PTE_A = 6;
    localparam int PTE_D = 7;

    localparam int PPN_MSB  = 31;
    localparam int PPN_LSB  = 10;
    localparam int PPN1_LSB = 20;
    localparam int PPN0_MSB = 19;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WALK = 1'b1
    } state_t;

    typedef struct packed {
        logic d;
        logic a;
        logic u;
        logic x;
        logic w;
        logic r;
    } flags_t;

    function automatic flags_t pte_flags(input logic [31:0] pte);
        return {pte[PTE_D], pte[PTE_A], pte[PTE_U], pte[PTE_X], pte[PTE_W], pte[PTE_R]};
    endfunction

    // High when the access must fault; A/D are checked, never updated.
    function automatic logic sv32_perm_fault(
        input flags_t     f,
        input logic       mega,
        input logic [9:0] ppn0,
        input logic [1:0] access_type,
        input logic [1:0] priv,
        input logic       sum,
        input logic       mxr
    );
        logic rsvd, type_fail, priv_fail, ad_fail, align_fail;
        rsvd       = (f.w & ~f.r) | (access_type == ACC_RSVD);
        type_fail  = ((access_type == ACC_FETCH) & ~f.x)
                   | ((access_type == ACC_LOAD)  & ~(f.r | (f.x & mxr)))
                   | ((access_type == ACC_STORE) & ~f.w);
        priv_fail  = (priv == PRIV_U) ? ~f.u
                                      : (f.u & ((access_type == ACC_FETCH) | ~sum));
        ad_fail    = ~f.a | ((access_type == ACC_STORE) & ~f.d);
        align_fail = mega & (ppn0 != 10'd0);
        return rsvd | type_fail | priv_fail | ad_fail | align_fail;
    endfunction

endpackage

// File: rtl/sv32_translate_access_if.sv
// Core request/response port plus page-table-walker handshake of the translation unit.
interface sv32_translate_access_if;
    logic        valid;
    logic        ready;
    logic [31:0] address;
    logic [1:0]  access_type;
    logic [1:0]  privilege_mode;
    logic [33:0] physical_address;
    logic        page_fault;
    logic        walk_valid;
    logic        walk_ready;
    logic [31:0] pte;
    logic        pte_mega;
    logic        walk_fault;

    modport master (
        output valid, address, access_type, privilege_mode, walk_ready, pte, pte_mega, walk_fault,
        input  ready, physical_address, page_fault, walk_valid
    );

    modport slave (
        input  valid, address, access_type, privilege_mode, walk_ready, pte, pte_mega, walk_fault,
        output ready, physical_address, page_fault, walk_valid
    );
endinterface

// File: rtl/sv32_tlb.sv
// Fully-associative Sv32 TLB: parallel match, one-hot read mux,
// first-invalid / round-robin victim choice, flush beats fill.
module sv32_tlb
    import sv32_pkg::*;
#(
    parameter int TLB_ENTRIES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [19:0] lookup_vpn,
    output logic        hit,
    output logic        hit_mega,
    output logic [21:0] hit_ppn,
    output logic [5:0]  hit_flags,
    input  logic        fill_en,
    input  logic        fill_mega,
    input  logic [19:0] fill_vpn,
    input  logic [21:0] fill_ppn,
    input  logic [5:0]  fill_flags
);
    localparam int IDX_W = (TLB_ENTRIES > 1) ? $clog2(TLB_ENTRIES) : 1;

    logic [TLB_ENTRIES-1:0] valid_r;
    logic [TLB_ENTRIES-1:0] mega_r;
    logic [TLB_ENTRIES-1:0] match_s;
    logic [19:0]            vpn_r   [TLB_ENTRIES];
    logic [21:0]            ppn_r   [TLB_ENTRIES];
    logic [5:0]             flags_r [TLB_ENTRIES];
    logic [IDX_W-1:0]       rr_r;
    logic [IDX_W-1:0]       victim_s;

    // Tag compare; megapage entries ignore VPN[9:0]. Matches are one-hot, so OR-ing is a mux.
    always_comb begin
        hit       = 1'b0;
        hit_mega  = 1'b0;
        hit_ppn   = 22'd0;
        hit_flags = 6'd0;
        match_s   = '0;
        for (int i = 0; i < TLB_ENTRIES; i++) begin
            match_s[i] = valid_r[i] & (mega_r[i] ? (vpn_r[i][19:10] == lookup_vpn[19:10])
                                                 : (vpn_r[i] == lookup_vpn));
            hit       = hit | match_s[i];
            hit_mega  = hit_mega | (match_s[i] & mega_r[i]);
            hit_ppn   = hit_ppn | ({22{match_s[i]}} & ppn_r[i]);
            hit_flags = hit_flags | ({6{match_s[i]}} & flags_r[i]);
        end
    end

    // Victim: lowest-index invalid entry, otherwise the round-robin pointer.
    always_comb begin
        victim_s = rr_r;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            victim_s = valid_r[i] ? victim_s : IDX_W'(i);
        end
    end

    // Valid bits and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= '0;
            rr_r    <= '0;
        end else if (flush) begin
            valid_r <= '0;
            rr_r    <= rr_r;
        end else if (fill_en) begin
            valid_r[victim_s] <= 1'b1;
            rr_r <= (rr_r == IDX_W'(TLB_ENTRIES - 1)) ? '0 : rr_r + IDX_W'(1);
        end else begin
            valid_r <= valid_r;
            rr_r    <= rr_r;
        end
    end

    // Entry payload; contents are only observed through a set valid bit.
    always_ff @(posedge clk) begin
        if (fill_en && !flush) begin
            mega_r[victim_s]  <= fill_mega;
            vpn_r[victim_s]   <= fill_vpn;
            ppn_r[victim_s]   <= fill_ppn;
            flags_r[victim_s] <= fill_flags;
        end
    end

endmodule

// File: rtl/sv32_translate_access.sv
// Sv32 translation front end: bypass, TLB lookup, walker handshake,
// permission check and registered single-cycle response.
module sv32_translate_access
    import sv32_pkg::*;
#(
    parameter int TLB_ENTRIES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic satp_sv32_mode,
    input  logic mstatus_sum,
    input  logic mstatus_mxr,
    input  logic tlb_flush,
    sv32_translate_access_if.slave bus
);
    state_t      state_r, state_s;
    logic        ready_r, ready_s;
    logic        fault_r, fault_s;
    logic [33:0] pa_r, pa_s;
    logic        req_fire_s, bypass_s, fill_en_s;
    logic        tlb_hit_s, tlb_hit_mega_s;
    logic [21:0] tlb_ppn_s;
    logic [5:0]  tlb_flags_s;
    logic [33:0] hit_pa_s, walk_pa_s;
    logic        hit_fault_s, walk_fault_s;
    flags_t      walk_flags_s;
    logic        unused_pte_bits_s;

    assign req_fire_s   = bus.valid & ~ready_r;
    assign bypass_s     = (bus.privilege_mode == PRIV_M) | ~satp_sv32_mode;
    assign walk_flags_s = pte_flags(bus.pte);
    assign unused_pte_bits_s = ^{bus.pte[9:8], bus.pte[PTE_G], bus.pte[PTE_V]};

    assign hit_pa_s = tlb_hit_mega_s ? {tlb_ppn_s[21:10], bus.address[21:0]}
                                     : {tlb_ppn_s, bus.address[11:0]};
    assign hit_fault_s = sv32_perm_fault(flags_t'(tlb_flags_s), tlb_hit_mega_s, tlb_ppn_s[9:0],
                                         bus.access_type, bus.privilege_mode,
                                         mstatus_sum, mstatus_mxr);

    // A walker fault carries no usable PTE, so the address is forced to zero.
    assign walk_pa_s = bus.walk_fault ? 34'd0
                     : (bus.pte_mega ? {bus.pte[PPN_MSB:PPN1_LSB], bus.address[21:0]}
                                     : {bus.pte[PPN_MSB:PPN_LSB], bus.address[11:0]});
    assign walk_fault_s = bus.walk_fault
                        | sv32_perm_fault(walk_flags_s, bus.pte_mega, bus.pte[PPN0_MSB:PPN_LSB],
                                          bus.access_type, bus.privilege_mode,
                                          mstatus_sum, mstatus_mxr);

    sv32_tlb #(.TLB_ENTRIES(TLB_ENTRIES)) u_tlb (
        .clk        (clk),
        .reset      (reset),
        .flush      (tlb_flush),
        .lookup_vpn (bus.address[31:12]),
        .hit        (tlb_hit_s),
        .hit_mega   (tlb_hit_mega_s),
        .hit_ppn    (tlb_ppn_s),
        .hit_flags  (tlb_flags_s),
        .fill_en    (fill_en_s),
        .fill_mega  (bus.pte_mega),
        .fill_vpn   (bus.address[31:12]),
        .fill_ppn   (bus.pte[PPN_MSB:PPN_LSB]),
        .fill_flags (walk_flags_s)
    );

    // Next state and response; only clean walk results are cached.
    always_comb begin
        state_s   = state_r;
        ready_s   = 1'b0;
        fault_s   = 1'b0;
        pa_s      = 34'd0;
        fill_en_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_fire_s && bypass_s) begin
                    ready_s = 1'b1;
                    pa_s    = {2'b00, bus.address};
                    fault_s = (bus.access_type == ACC_RSVD);
                end else if (req_fire_s && tlb_hit_s) begin
                    ready_s = 1'b1;
                    pa_s    = hit_pa_s;
                    fault_s = hit_fault_s;
                end else if (req_fire_s) begin
                    state_s = ST_WALK;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WALK: begin
                if (bus.walk_ready) begin
                    ready_s   = 1'b1;
                    pa_s      = walk_pa_s;
                    fault_s   = walk_fault_s;
                    fill_en_s = ~walk_fault_s;
                    state_s   = ST_IDLE;
                end else begin
                    state_s = ST_WALK;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State and registered response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b0;
            fault_r <= 1'b0;
            pa_r    <= 34'd0;
        end else begin
            state_r <= state_s;
            ready_r <= ready_s;
            fault_r <= fault_s;
            pa_r    <= pa_s;
        end
    end

    assign bus.ready            = ready_r;
    assign bus.page_fault       = fault_r;
    assign bus.physical_address = pa_r;
    assign bus.walk_valid       = (state_r == ST_WALK) && !reset;

endmodule

// File: tb/tb_sv32_translate_access.sv
// Directed bench for sv32_translate_access: expected responses are queued at issue
// time and a negedge monitor pops and compares them whenever ready pulses.
module tb_sv32_translate_access;
    import sv32_pkg::*;

    typedef struct {
        string       name;
        logic [33:0] pa;
        logic        fault;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic satp_sv32_mode = 1'b0;
    logic mstatus_sum = 1'b0;
    logic mstatus_mxr = 1'b0;
    logic tlb_flush = 1'b0;
    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];

    sv32_translate_access_if ifc();

    sv32_translate_access #(.TLB_ENTRIES(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .satp_sv32_mode (satp_sv32_mode),
        .mstatus_sum    (mstatus_sum),
        .mstatus_mxr    (mstatus_mxr),
        .tlb_flush      (tlb_flush),
        .bus            (ifc)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Response monitor: every ready pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (ifc.ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_ready: pa=%h fault=%b with nothing outstanding",
                         ifc.physical_address, ifc.page_fault);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (ifc.physical_address !== e.pa || ifc.page_fault !== e.fault) begin
                    fails++;
                    $display("FAIL %s: pa=%h fault=%b, expected pa=%h fault=%b",
                             e.name, ifc.physical_address, ifc.page_fault, e.pa, e.fault);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, act as the walker, and check latency and whether a walk happened.
    task automatic do_req(input string name, input logic [31:0] va, input logic [1:0] acc,
                          input logic [1:0] priv, input logic sum, input logic satp,
                          input int delay, input logic [31:0] pte_v, input logic mega,
                          input logic wfault, input int flush_mode, input logic exp_walk,
                          input logic [33:0] exp_pa, input logic exp_fault);
        exp_t e;
        int   cyc;
        int   wcnt;
        logic walked;
        logic done;
        e.name = name; e.pa = exp_pa; e.fault = exp_fault;
        exp_q.push_back(e);
        ifc.address = va; ifc.access_type = acc; ifc.privilege_mode = priv;
        mstatus_sum = sum; satp_sv32_mode = satp;
        tlb_flush = (flush_mode == 1);
        ifc.valid = 1'b1;
        cyc = 0; wcnt = 0; walked = 1'b0; done = 1'b0;
        while (!done && cyc < 64) begin
            step();
            cyc++;
            tlb_flush = 1'b0;
            ifc.walk_ready = 1'b0;
            if (ifc.ready) begin
                done = 1'b1;
            end else if (ifc.walk_valid) begin
                walked = 1'b1;
                wcnt++;
                if (wcnt == delay) begin
                    ifc.walk_ready = 1'b1;
                    ifc.pte = pte_v;
                    ifc.pte_mega = mega;
                    ifc.walk_fault = wfault;
                    tlb_flush = (flush_mode == 2);
                end
            end
        end
        ifc.valid = 1'b0;
        ifc.walk_fault = 1'b0;
        check({name, "_done"}, 64'(done), 64'd1);
        if (done) begin
            check({name, "_latency"}, 64'(cyc), exp_walk ? 64'(delay + 1) : 64'd1);
            check({name, "_walked"}, 64'(walked), 64'(exp_walk));
        end
        step();
    endtask

    initial begin
        ifc.valid = 1'b0; ifc.address = 32'd0; ifc.access_type = 2'd0; ifc.privilege_mode = 2'd0;
        ifc.walk_ready = 1'b0; ifc.pte = 32'd0; ifc.pte_mega = 1'b0; ifc.walk_fault = 1'b0;
        repeat (3) step();
        check("rst_ready", 64'(ifc.ready), 64'd0);
        check("rst_fault", 64'(ifc.page_fault), 64'd0);
        check("rst_walk_valid", 64'(ifc.walk_valid), 64'd0);
        check("rst_pa", 64'(ifc.physical_address), 64'd0);
        reset = 1'b0;
        step();

        // name va acc priv sum satp delay pte mega wfault flush walk pa fault
        do_req("m_bypass", 32'h8000_1234, ACC_LOAD, PRIV_M, 1'b0, 1'b1, 1, 32'h0, 1'b0, 1'b0, 0, 1'b0, 34'h0_8000_1234, 1'b0);
        do_req("satp_off", 32'h1234_5678, ACC_STORE, PRIV_S, 1'b0, 1'b0, 1, 32'h0, 1'b0, 1'b0, 0, 1'b0, 34'h0_1234_5678, 1'b0);
        do_req("walk_fault", 32'h0200_0000, ACC_LOAD, PRIV_S, 1'b0, 1'b1, 1, 32'h2000_00CF, 1'b0, 1'b1, 0, 1'b1, 34'h0, 1'b1);
        do_req("s_load_miss", 32'h4000_0ABC, ACC_LOAD, PRIV_S, 1'b0, 1'b1, 3, 32'h2000_00CF, 1'b0, 1'b0, 0, 1'b1, 34'h0_8000_0ABC, 1'b0);
        do_req("s_load_hit", 32'h4000_0ABC, ACC_LOAD, PRIV_S, 1'b0, 1'b1, 1, 32'h0, 1'b0, 1'b0, 0, 1'b0, 34'h0_8000_0ABC, 1'b0);
        do_req("u_fetch_nx", 32'h0040_1000, ACC_FETCH, PRIV_U, 1'b0, 1'b1, 2, 32'h2000_04D3, 1'b0, 1'b0, 0, 1'b1, 34'h0_8000_1000, 1'b1);
        do_req("u_fetch_retry", 32'h0040_1000, ACC_FETCH, PRIV_U, 1'b0, 1'b1, 2, 32'h2000_04D3, 1'b0, 1'b0, 0, 1'b1, 34'h0_8000_1000, 1'b1);
        do_req("mega_miss", 32'h0012_3456, ACC_LOAD, PRIV_S, 1'b0, 1'b1, 1, 32'h2000_00CB, 1'b1, 1'b0, 0, 1'b1, 34'h0_8012_3456, 1'b0);
        do_req("mega_hit", 32'h0012_3458, ACC_LOAD, PRIV_S, 1'b0, 1'b1, 1, 32'h0, 1'b0, 1'b0, 0, 1'b0, 34'h0_8012_3458, 1'b0);
        do_req("mega_misalign", 32'h0080_0010, ACC_LOAD, PRIV_S, 1'b0, 1'b1, 1, 32'h2000_04CB, 1'b1, 1'b0, 0, 1'b1, 34'h0_8000_0010, 1'b1);
        do_req("d0_load", 32'h00C0_5010, ACC_LOAD, PRIV_S, 1'b0, 1'b1, 2, 32'h2000_2047, 1'b0, 1'b0, 0, 1'b1, 34'h0_8000_8010, 1'b0);
        do_req("d0_store_hit", 32'h00C0_5010, ACC_STORE, PRIV_S, 1'b0, 1'b1, 1, 32'h0, 1'b0, 1'b0, 0, 1'b0, 34'h0_8000_8010, 1'b1);
        do_req("sum0_miss", 32'h0100_3020, ACC_LOAD, PRIV_S, 1'b0, 1'b1, 1, 32'h2000_30D3, 1'b0, 1'b0, 0, 1'b1, 34'h0_8000_C020, 1'b1);
        do_req("sum1_miss", 32'h0100_3020, ACC_LOAD, PRIV_S, 1'b1, 1'b1, 1, 32'h2000_30D3, 1'b0, 1'b0, 0, 1'b1, 34'h0_8000_C020, 1'b0);
        do_req("sum0_hit", 32'h0100_3020, ACC_LOAD, PRIV_S, 1'b0, 1'b1, 1, 32'h0, 1'b0, 1'b0, 0, 1'b0, 34'h0_8000_C020, 1'b1);
        do_req("rr_fill", 32'h0140_7000, ACC_LOAD, PRIV_S, 1'b0, 1'b1, 1, 32'h2000_00CF, 1'b0, 1'b0, 0, 1'b1, 34'h0_8000_0000, 1'b0);
        do_req("rr_evicted", 32'h4000_0ABC, ACC_LOAD, PRIV_S, 1'b0, 1'b1, 2, 32'h2000_00CF, 1'b0, 1'b0, 0, 1'b1, 34'h0_8000_0ABC, 1'b0);
        do_req("flush_on_hit", 32'h0140_7010, ACC_LOAD, PRIV_S, 1'b0, 1'b1, 1, 32'h0, 1'b0, 1'b0, 1, 1'b0, 34'h0_8000_0010, 1'b0);
        do_req("flush_with_fill", 32'h4000_0ABC, ACC_LOAD, PRIV_S, 1'b0, 1'b1, 2, 32'h2000_00CF, 1'b0, 1'b0, 2, 1'b1, 34'h0_8000_0ABC, 1'b0);
        do_req("after_flush_fill", 32'h4000_0ABC, ACC_LOAD, PRIV_S, 1'b0, 1'b1, 1, 32'h2000_00CF, 1'b0, 1'b0, 0, 1'b1, 34'h0_8000_0ABC, 1'b0);

        // Reset in the middle of a walk; no response may come back for it.
        ifc.address = 32'h0140_7000; ifc.access_type = ACC_LOAD; ifc.privilege_mode = PRIV_S;
        ifc.valid = 1'b1;
        repeat (2) step();
        check("midwalk_walk_valid", 64'(ifc.walk_valid), 64'd1);
        reset = 1'b1;
        step();
        ifc.valid = 1'b0;
        check("midrst_ready", 64'(ifc.ready), 64'd0);
        check("midrst_fault", 64'(ifc.page_fault), 64'd0);
        check("midrst_walk_valid", 64'(ifc.walk_valid), 64'd0);
        check("midrst_pa", 64'(ifc.physical_address), 64'd0);
        step();
        reset = 1'b0;
        ifc.walk_ready = 1'b1; ifc.pte = 32'h2000_00CF;
        step();
        ifc.walk_ready = 1'b0;
        check("stale_walk_valid", 64'(ifc.walk_valid), 64'd0);
        repeat (2) step();

        do_req("after_reset", 32'h4000_0ABC, ACC_LOAD, PRIV_S, 1'b0, 1'b1, 1, 32'h2000_00CF, 1'b0, 1'b0, 0, 1'b1, 34'h0_8000_0ABC, 1'b0);
        repeat (2) step();
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
